// File: rtl/keypad_emulator.sv
// Keypad matrix emulator: queues digits 1..9 and plays them back as timed key
// closures, answering the scanner's active-low row drive on the column lines.
module keypad_emulator #(
    parameter int HOLD_CYCLES = 1200000,
    parameter int GAP_CYCLES  = 1200000,
    parameter int DEPTH       = 8
) (
    input  logic                     hwclk,
    input  logic                     hwrst_n,
    input  logic                     push_valid,
    input  logic [3:0]               push_digit,
    output logic                     push_ready,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     keypad_r1,
    input  logic                     keypad_r2,
    input  logic                     keypad_r3,
    output logic                     keypad_c1,
    output logic                     keypad_c2,
    output logic                     keypad_c3
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, GAP = 2'd2} state_t;

    function automatic logic digit_ok(input logic [3:0] d);
        return (d >= 4'd1) && (d <= 4'd9);
    endfunction

    // One-hot row of a digit; zero for "no key".
    function automatic logic [2:0] row_mask(input logic [3:0] d);
        case (d)
            4'd1, 4'd2, 4'd3: return 3'b001;
            4'd4, 4'd5, 4'd6: return 3'b010;
            4'd7, 4'd8, 4'd9: return 3'b100;
            default:          return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] col_mask(input logic [3:0] d);
        case (d)
            4'd1, 4'd4, 4'd7: return 3'b001;
            4'd2, 4'd5, 4'd8: return 3'b010;
            4'd3, 4'd6, 4'd9: return 3'b100;
            default:          return 3'b000;
        endcase
    endfunction

    state_t          state_r, state_n;
    logic [CW-1:0]   cnt_r, cnt_n;
    logic [3:0]      key_r, key_n;
    logic [3:0]      mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [LW-1:0]   level_r;
    logic            busy_r, done_r, err_r, done_n;
    logic            pop_s, push_acc_s, push_wr_s;
    logic [2:0]      rows_s, col_low_s;

    assign push_ready = (level_r < LVL_FULL);
    assign push_acc_s = push_valid & push_ready & ~abort;
    assign push_wr_s  = push_acc_s & digit_ok(push_digit);

    // Only combinational path: closure appears when the key's row is driven low.
    assign rows_s     = {keypad_r3, keypad_r2, keypad_r1};
    assign col_low_s  = (|(row_mask(key_r) & ~rows_s)) ? col_mask(key_r) : 3'b000;
    assign keypad_c1  = ~col_low_s[0];
    assign keypad_c2  = ~col_low_s[1];
    assign keypad_c3  = ~col_low_s[2];

    assign busy  = busy_r;
    assign done  = done_r;
    assign err   = err_r;
    assign level = level_r;

    // Playback sequencing: next state, counter, key and pop/done strobes.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        key_n   = key_r;
        pop_s   = 1'b0;
        done_n  = 1'b0;
        if (abort) begin
            state_n = IDLE;
            cnt_n   = CNT_ZERO;
            key_n   = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && (level_r != LVL_ZERO)) begin
                        pop_s   = 1'b1;
                        key_n   = mem_r[rd_ptr_r];
                        cnt_n   = HOLD_LOAD;
                        state_n = PRESS;
                    end else if (start) begin
                        done_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                PRESS: begin
                    if (cnt_r == CNT_ZERO) begin
                        key_n   = 4'd0;
                        cnt_n   = GAP_LOAD;
                        state_n = GAP;
                    end else begin
                        cnt_n   = cnt_r - CNT_ONE;
                    end
                end
                GAP: begin
                    if ((cnt_r == CNT_ZERO) && (level_r != LVL_ZERO)) begin
                        pop_s   = 1'b1;
                        key_n   = mem_r[rd_ptr_r];
                        cnt_n   = HOLD_LOAD;
                        state_n = PRESS;
                    end else if (cnt_r == CNT_ZERO) begin
                        key_n   = 4'd0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n   = cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = CNT_ZERO;
                    key_n   = 4'd0;
                end
            endcase
        end
    end

    // FSM, key and status registers.
    always_ff @(posedge hwclk or negedge hwrst_n) begin
        if (!hwrst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            key_r   <= 4'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            key_r   <= key_n;
            busy_r  <= (state_n != IDLE);
            done_r  <= done_n;
            err_r   <= push_acc_s & ~digit_ok(push_digit);
        end
    end

    // Digit FIFO; abort flushes it and drops any same-cycle push.
    always_ff @(posedge hwclk or negedge hwrst_n) begin
        if (!hwrst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= LVL_ZERO;
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= 4'd0;
        end else if (abort) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_wr_s) begin
                mem_r[wr_ptr_r] <= push_digit;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_wr_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// Directed self-checking bench for keypad_emulator with HOLD=4, GAP=3, DEPTH=4.
module tb_keypad_emulator;
    logic       hwclk = 1'b0;
    logic       hwrst_n = 1'b0;
    logic       push_valid = 1'b0;
    logic [3:0] push_digit = 4'd0;
    logic       push_ready;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, err;
    logic [2:0] level;
    logic       keypad_r1 = 1'b1, keypad_r2 = 1'b1, keypad_r3 = 1'b1;
    logic       keypad_c1, keypad_c2, keypad_c3;
    int         passed = 0;
    int         total = 0;

    keypad_emulator #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .DEPTH(4)) dut (
        .hwclk(hwclk), .hwrst_n(hwrst_n),
        .push_valid(push_valid), .push_digit(push_digit), .push_ready(push_ready),
        .start(start), .abort(abort), .busy(busy), .done(done), .err(err), .level(level),
        .keypad_r1(keypad_r1), .keypad_r2(keypad_r2), .keypad_r3(keypad_r3),
        .keypad_c1(keypad_c1), .keypad_c2(keypad_c2), .keypad_c3(keypad_c3)
    );

    always #5 hwclk = ~hwclk;

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        push_valid = 1'b1; push_digit = d;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic set_rows(input logic [2:0] r);
        {keypad_r3, keypad_r2, keypad_r1} = r;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        set_rows(3'b111);
    endtask

    task automatic test_reset();
        hwrst_n = 1'b0;
        #23;
        hwrst_n = 1'b1;
        tick();
        total++; if ({keypad_c3, keypad_c2, keypad_c1} !== 3'b111) $display("FAIL rst_cols got=%b exp=111", {keypad_c3, keypad_c2, keypad_c1}); else passed++;
        total++; if (level !== 3'd0) $display("FAIL rst_level got=%0d exp=0", level); else passed++;
        total++; if ({busy, done, err} !== 3'b000) $display("FAIL rst_flags got=%b exp=000", {busy, done, err}); else passed++;
        total++; if (push_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", push_ready); else passed++;
    endtask

    task automatic test_async_reset();
        push(4'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_rows(3'b101);
        tick();
        #1;
        total++; if (keypad_c2 !== 1'b0) $display("FAIL areset_pre_c2 got=%b exp=0", keypad_c2); else passed++;
        hwrst_n = 1'b0;
        #1;
        total++; if (keypad_c2 !== 1'b1) $display("FAIL areset_c2 got=%b exp=1", keypad_c2); else passed++;
        total++; if (level !== 3'd0) $display("FAIL areset_level got=%0d exp=0", level); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL areset_busy got=%b exp=0", busy); else passed++;
        #1;
        hwrst_n = 1'b1;
        set_rows(3'b111);
        tick();
    endtask

    task automatic test_single_key();
        logic exp_c2;
        push(4'd5);
        total++; if (level !== 3'd1) $display("FAIL single_level got=%0d exp=1", level); else passed++;
        start = 1'b1;
        set_rows(3'b101);
        for (int k = 1; k <= 10; k++) begin
            tick();
            start = 1'b0;
            exp_c2 = (k >= 1 && k <= 4) ? 1'b0 : 1'b1;
            total++; if (keypad_c2 !== exp_c2) $display("FAIL single_c2 k=%0d got=%b exp=%b", k, keypad_c2, exp_c2); else passed++;
            total++; if ({keypad_c3, keypad_c1} !== 2'b11) $display("FAIL single_c13 k=%0d got=%b exp=11", k, {keypad_c3, keypad_c1}); else passed++;
            total++; if (done !== (k == 8)) $display("FAIL single_done k=%0d got=%b exp=%b", k, done, (k == 8)); else passed++;
            total++; if (busy !== (k <= 7)) $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, (k <= 7)); else passed++;
        end
        set_rows(3'b111);
    endtask

    task automatic test_row_gating();
        push(4'd9);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_rows(3'b110);
        #1;
        total++; if ({keypad_c3, keypad_c2, keypad_c1} !== 3'b111) $display("FAIL gate_r1 got=%b exp=111", {keypad_c3, keypad_c2, keypad_c1}); else passed++;
        set_rows(3'b010);
        #1;
        total++; if ({keypad_c3, keypad_c2, keypad_c1} !== 3'b011) $display("FAIL gate_r3 got=%b exp=011", {keypad_c3, keypad_c2, keypad_c1}); else passed++;
        do_abort();
        total++; if ({level, busy, done} !== 5'b00000) $display("FAIL gate_abort got=%b exp=00000", {level, busy, done}); else passed++;
    endtask

    task automatic test_full_fifo();
        push(4'd1); push(4'd2); push(4'd3); push(4'd4);
        total++; if (level !== 3'd4) $display("FAIL full_level got=%0d exp=4", level); else passed++;
        total++; if (push_ready !== 1'b0) $display("FAIL full_ready got=%b exp=0", push_ready); else passed++;
        push(4'd5);
        total++; if (level !== 3'd4) $display("FAIL full_5th got=%0d exp=4", level); else passed++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (level !== 3'd3) $display("FAIL full_pop got=%0d exp=3", level); else passed++;
        total++; if (push_ready !== 1'b1) $display("FAIL full_ready2 got=%b exp=1", push_ready); else passed++;
        total++; if (err !== 1'b0) $display("FAIL full_err_pre got=%b exp=0", err); else passed++;
        push(4'd0);
        total++; if (err !== 1'b1) $display("FAIL full_err got=%b exp=1", err); else passed++;
        total++; if (level !== 3'd3) $display("FAIL full_err_level got=%0d exp=3", level); else passed++;
        tick();
        total++; if (err !== 1'b0) $display("FAIL full_err_pulse got=%b exp=0", err); else passed++;
        do_abort();
    endtask

    task automatic test_sequence();
        logic [3:0] digits [4];
        logic [3:0] d;
        int         seg, off, row, col;
        logic [2:0] exp_cols;
        digits[0] = 4'd1; digits[1] = 4'd2; digits[2] = 4'd3; digits[3] = 4'd7;
        push(4'd1); push(4'd2); push(4'd3);
        start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            start = 1'b0;
            if (k == 13) push_valid = 1'b0;
            seg = (k - 1) / 7;
            off = (k - 1) % 7;
            d = (seg < 4 && off < 4) ? digits[seg] : 4'd0;
            if (d != 4'd0) begin
                row = (int'(d) - 1) / 3;
                col = (int'(d) - 1) % 3;
                set_rows(~(3'b001 << row));
                exp_cols = ~(3'b001 << col);
            end else begin
                set_rows(3'b000);
                exp_cols = 3'b111;
            end
            #1;
            total++; if ({keypad_c3, keypad_c2, keypad_c1} !== exp_cols) $display("FAIL seq_cols k=%0d got=%b exp=%b", k, {keypad_c3, keypad_c2, keypad_c1}, exp_cols); else passed++;
            total++; if (done !== (k == 29)) $display("FAIL seq_done k=%0d got=%b exp=%b", k, done, (k == 29)); else passed++;
            total++; if (busy !== (k < 29)) $display("FAIL seq_busy k=%0d got=%b exp=%b", k, busy, (k < 29)); else passed++;
            if (k == 12) begin
                push_valid = 1'b1;
                push_digit = 4'd7;
            end
        end
        set_rows(3'b111);
    endtask

    task automatic test_abort();
        int done_seen;
        push(4'd1); push(4'd2); push(4'd3);
        start = 1'b1;
        set_rows(3'b110);
        for (int k = 1; k <= 9; k++) begin
            tick();
            start = 1'b0;
        end
        total++; if (keypad_c2 !== 1'b0) $display("FAIL abort_pre_c2 got=%b exp=0", keypad_c2); else passed++;
        abort = 1'b1;
        push_valid = 1'b1;
        push_digit = 4'd6;
        tick();
        abort = 1'b0;
        push_valid = 1'b0;
        total++; if ({keypad_c3, keypad_c2, keypad_c1} !== 3'b111) $display("FAIL abort_cols got=%b exp=111", {keypad_c3, keypad_c2, keypad_c1}); else passed++;
        total++; if (level !== 3'd0) $display("FAIL abort_level got=%0d exp=0", level); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else passed++;
        done_seen = (done === 1'b1) ? 1 : 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1) done_seen++;
        end
        total++; if (done_seen !== 0) $display("FAIL abort_no_done got=%0d exp=0", done_seen); else passed++;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++; if (done !== 1'b1) $display("FAIL abort_empty_done got=%b exp=1", done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort_empty_busy got=%b exp=0", busy); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL abort_done_pulse got=%b exp=0", done); else passed++;
        set_rows(3'b111);
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_single_key();
        test_row_gating();
        test_full_fifo();
        test_sequence();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Keypad matrix emulator: the opposite end of the 3x3 keypad interface read by the lock's `enterDigit` scanner. It queues digits 1–9 and plays them back as timed key presses. During each press it answers the scanner's row drive with the matching column drive, exactly as a physical key closure would. It sits in place of the keypad pins for self-test and scripted unlock sequences, so the `enterDigit`, `lengthChecker`, `validChecker` and `controller` chain can be exercised without a human pressing keys.

## Interface
Parameters:
- `HOLD_CYCLES`, 1200000: number of `hwclk` cycles each key is held (100 ms at 12 MHz).
- `GAP_CYCLES`, 1200000: number of released cycles between keys.
- `DEPTH`, 8: digit FIFO depth. Must be a power of two, 2..16.

Ports:
- `hwclk`  in  1  single clock; everything is on its rising edge.
- `hwrst_n`  in  1  asynchronous, active-low reset.
- `push_valid`  in  1  digit offered.
- `push_digit`  in  4  digit value; 1..9 valid.
- `push_ready`  out  1  FIFO can accept this cycle.
- `start`  in  1  begin playback; single-cycle pulse.
- `abort`  in  1  stop playback and flush the FIFO.
- `busy`  out  1  high while the state is PRESS or GAP.
- `done`  out  1  one-cycle pulse at the end of playback.
- `err`  out  1  one-cycle pulse when an invalid digit is accepted.
- `level`  out  clog2(DEPTH)+1  FIFO occupancy.
- `keypad_r1`..`keypad_r3`  in  1 each  row drives from the scanner; active-low.
- `keypad_c1`..`keypad_c3`  out  1 each  column returns; idle high, driven low on a key closure.

## Operation
- **Key map.** Digit d (1..9) maps to row r = (d-1)/3 + 1 and column c = (d-1)%3 + 1.
- **Key register.** `key` holds the active digit, or 0 when no key is pressed.
- **Column logic.** `keypad_cj` = 0 iff `key` != 0, column(`key`) == j, and `keypad_r`(row(`key`)) == 0.
  - This is the only combinational path in the block: from the row inputs plus the registered `key` to the column outputs.
  - If several rows are low at once, the rule above still applies per row, so the closure appears if its row is among those driven low.
- **FIFO push.**
  - `push_ready` = (`level` < DEPTH), computed from the registered `level` only.
  - A push is accepted when `push_valid` and `push_ready` are both high.
  - An accepted digit of 0 or 10..15 is discarded and pulses `err` for one cycle.
- **FSM states: IDLE, PRESS, GAP.**
- **IDLE.**
  - `start` with `level` > 0: pop the head digit into `key`, load the counter with HOLD_CYCLES-1, go to PRESS.
  - `start` with `level` = 0: pulse `done` next cycle and stay in IDLE.
- **PRESS.** The counter decrements each cycle. At 0: set `key` = 0, load GAP_CYCLES-1, go to GAP.
- **GAP.** The counter decrements each cycle. At 0:
  - if `level` > 0: pop the next digit into `key`, load HOLD_CYCLES-1, go to PRESS;
  - otherwise go to IDLE and pulse `done`.
- **Pushing during playback** is allowed. A digit pushed before GAP ends is played in the same run.
- **Simultaneous push and pop:** both take effect and `level` is unchanged.
- **`abort`** has priority over `start` and over counter expiry. On the next edge: `key` = 0, FIFO flushed, state IDLE. No `done` pulse. A push in the same cycle as `abort` is dropped.
- **`start` while `busy`** is ignored.
- **Counter width** is clog2(max(HOLD_CYCLES, GAP_CYCLES)). It never wraps, because it is reloaded before it can underflow.

## Timing
- **Reset values:** state IDLE, `key` 0, `level` 0, `busy` 0, `done` 0, `err` 0, `push_ready` 1, all columns 1.
- **Reset is asynchronous.** Asserting `hwrst_n` low mid-press releases all columns immediately, without waiting for a clock edge.
- **Start latency:** with `start` sampled at edge 0, `key` is valid and `busy` = 1 from edge 1.
- **Press and gap lengths:** `key` is nonzero for exactly HOLD_CYCLES cycles and zero for exactly GAP_CYCLES cycles between keys.
- **Run length:** for N queued digits, `done` pulses N·(HOLD_CYCLES+GAP_CYCLES)+1 cycles after the `start` edge. `busy` falls in the same cycle as `done`.
- **`err` timing:** `err` is asserted in the cycle after the accepting edge.

## Test plan
All scenarios use HOLD_CYCLES=4, GAP_CYCLES=3, DEPTH=4.
- **Reset:** assert `hwrst_n`=0 asynchronously during PRESS of digit 5 -> `keypad_c2` returns to 1 with no clock edge, `level`=0, `busy`=0.
- **Single key:** push 5, start, hold `keypad_r2`=0 -> `keypad_c2`=0 for exactly 4 cycles starting at edge 1; `done` pulses at cycle 8; `keypad_c1`/`keypad_c3` stay 1.
- **Row gating:** during the press of digit 9, drive only `keypad_r1` low -> all columns stay 1; then drive `keypad_r3` low -> `keypad_c3`=0 in the same cycle.
- **Full FIFO and invalid digit:** push 1,2,3,4 -> `push_ready`=0 with `level`=4; a 5th push is not accepted; after one pop, push 0 -> `err` pulse, `level` unchanged.
- **Sequence with mid-run push:** queue 1,2,3; start; push 7 during the second GAP -> closures on (r1,c1), (r1,c2), (r1,c3), (r3,c1) in order; `done` at cycle 4·7+1=29.
- **Abort:** assert `abort` during PRESS of the second of three digits -> columns released next edge, `level`=0, state IDLE, no `done`; a following `start` gives `done` after 1 cycle.
